alien_sprite_renderer: RTL and testbench
========================================

// Module: alien_sprite_renderer
// PURPOSE
//  Draw stage between the VGA controller and the alien sprite RAM (50x50, 24-bit RGB, 1-cycle read latency).
//  - Keeps the marching alien formation origin: one step every FRAMES_PER_STEP frames.
//  - Maps DrawX/DrawY to a sprite RAM read address.
//  - Aligns returned sprite data with a pipelined hit flag.
//  - Emits alien_on/alien_color to the colour mapper, with colour-key transparency and alive masking.
// PARAMETERS
//  SPRITE_W        50        sprite width, px
//  SPRITE_H        50        sprite height, px
//  COLS            8         aliens per row
//  ROWS            4         alien rows
//  PITCH_X         60        horizontal cell pitch, px (>= SPRITE_W)
//  PITCH_Y         60        vertical cell pitch, px (>= SPRITE_H)
//  START_X         20        origin X after reset
//  START_Y         40        origin Y after reset
//  STEP_X          4         horizontal step, px
//  STEP_Y          16        drop distance at an edge, px
//  RIGHT_BOUND     636       rightmost allowed formation pixel + 1
//  LEFT_BOUND      4         leftmost allowed formation pixel
//  LAND_Y          420       formation bottom limit
//  FRAMES_PER_STEP 8         frame_start pulses per march step (>= 1)
//  KEY_COLOR       24'hFF00FF transparent colour key
// PORTS
//  Clk          in   1          system clock
//  Reset        in   1          synchronous, active-high reset
//  frame_start  in   1          1-cycle pulse at start of vertical blank
//  DrawX        in   10         current pixel X
//  DrawY        in   10         current pixel Y
//  alive        in   ROWS*COLS  1 = alien present; bit index r*COLS+c
//  sprite_data  in   24         sprite RAM data_Out
//  read_address out  19         sprite RAM read address
//  alien_on     out  1          pixel belongs to a live, opaque alien
//  alien_color  out  24         RGB for the pixel; 0 when alien_on = 0
//  origin_x     out  10         formation top-left X
//  origin_y     out  10         formation top-left Y
//  landed       out  1          formation reached LAND_Y (sticky)
// BEHAVIOUR
//  Reset (Reset wins over every other input):
//   - origin = (START_X, START_Y); FSM = MARCH_R; step_cnt = 0.
//   - read_address = 0, alien_on = 0, alien_color = 0, landed = 0.
//   - Pipeline valid bits are cleared.
//  Formation extent: FORM_W = (COLS-1)*PITCH_X + SPRITE_W; FORM_H = (ROWS-1)*PITCH_Y + SPRITE_H.
//   Edge tests use the full extent regardless of alive.
//  Step counter:
//   - Increments on each frame_start.
//   - At FRAMES_PER_STEP-1 with frame_start high: wraps to 0 and issues a step.
//   - Origin changes only on a step, so a frame is never torn.
//  FSM MARCH_R / MARCH_L / LANDED. Each step is evaluated once:
//   - MARCH_R: if origin_x+STEP_X+FORM_W > RIGHT_BOUND, origin_y += STEP_Y and go to MARCH_L (no X move);
//     else origin_x += STEP_X.
//   - MARCH_L: if origin_x < LEFT_BOUND+STEP_X, origin_y += STEP_Y and go to MARCH_R; else origin_x -= STEP_X.
//   - Drop check: if the new origin_y+FORM_H >= LAND_Y, go to LANDED and set landed = 1.
//     LANDED freezes the origin until Reset.
//  Pixel pipeline (all stages registered; total latency 3 Clk from DrawX/DrawY to alien_on/alien_color):
//   - S1: rx = DrawX-origin_x, ry = DrawY-origin_y (11-bit signed; negative = miss).
//     Column and row are found by parallel range compare over COLS/ROWS cells (no divider).
//     In-sprite offsets are ox = rx-c*PITCH_X and oy = ry-r*PITCH_Y.
//     hit = inside extent && ox < SPRITE_W && oy < SPRITE_H && alive[r*COLS+c].
//     Register read_address = oy*SPRITE_W + ox (0 on miss) and hit1.
//   - S2: RAM returns sprite_data; hit2 <= hit1.
//   - S3: alien_on <= hit2 && sprite_data != KEY_COLOR; alien_color <= alien_on_next ? sprite_data : 0.
//  Boundaries:
//   - Gap pixels between cells and pixels outside the formation give alien_on = 0.
//   - DrawX/DrawY beyond the visible area behave as ordinary misses.
//   - A step landing on the same cycle as a pixel: S1 uses the old origin; the new origin applies next cycle.
//   - Reset mid-frame flushes the pipeline. Outputs stay 0 for 3 cycles after release.
// CONFIGURATION
//  ALIEN_ANIM_EN:
//   - Defined: a frame bit toggles on every step (reset 0).
//   - frame 1 adds SPRITE_W*SPRITE_H to read_address; the RAM holds two poses (5000 entries).
//   - Not defined: single pose, address range 0..SPRITE_W*SPRITE_H-1.
// STRUCTURE
//  Package alien_pkg:
//   - typedef enum logic [1:0] march_state_t {MARCH_R, MARCH_L, LANDED}.
//   - FORM_W / FORM_H localparam functions; KEY_COLOR constant.
//  Sub-module alien_march_fsm: step counter, FSM, origin registers, landed (and the frame bit when enabled).
//  The renderer top holds the 3-stage pixel pipeline.
// TESTING
//  1. Reset; DrawX=20, DrawY=40, alive all 1, RAM word0=24'h00FF00
//     -> read_address=0 at cycle 1; alien_on=1 and alien_color=24'h00FF00 at cycle 3.
//  2. DrawX=20+55 (gap), DrawY=40 -> alien_on=0 and alien_color=0 three cycles later;
//     DrawX=80, DrawY=41 -> read_address=50.
//  3. alive[9]=0; pixel inside row 1, col 1 -> alien_on=0; alive[9]=1 -> alien_on=1.
//  4. RAM word = KEY_COLOR at the addressed pixel -> alien_on=0 despite hit.
//  5. 8 frame_start pulses -> origin_x=24.
//     Continue until origin_x+4+470 > 636 -> next step leaves origin_x unchanged, origin_y=56, FSM=MARCH_L.
//  6. Run steps until origin_y+230 >= 420 -> landed=1 and origin frozen through 100 further frame_start pulses;
//     Reset -> origin (20,40), landed=0.

Source files
------------

// File: rtl/alien_sprite_renderer_pkg.sv
// Shared types and constants for the alien formation renderer and its march controller.
package alien_pkg;

   typedef enum logic [1:0] {
      MARCH_R = 2'd0,
      MARCH_L = 2'd1,
      LANDED  = 2'd2
   } march_state_t;

   localparam logic [23:0] KEY_COLOR = 24'hFF00FF;

   // Formation extent spans every cell, dead or alive.
   function automatic int form_w(input int cols, input int pitch_x, input int sprite_w);
      return (cols - 1) * pitch_x + sprite_w;
   endfunction

   function automatic int form_h(input int rows, input int pitch_y, input int sprite_h);
      return (rows - 1) * pitch_y + sprite_h;
   endfunction

endpackage

// File: rtl/alien_sprite_renderer_if.sv
// Pixel-side bus: VGA coordinates in, sprite RAM address/data, colour-mapper outputs.
interface alien_sprite_renderer_if;
   logic [9:0]  DrawX;
   logic [9:0]  DrawY;
   logic [18:0] read_address;
   logic [23:0] sprite_data;
   logic        alien_on;
   logic [23:0] alien_color;

   modport master (
      output DrawX, DrawY, sprite_data,
      input  read_address, alien_on, alien_color
   );

   modport slave (
      input  DrawX, DrawY, sprite_data,
      output read_address, alien_on, alien_color
   );
endinterface

// File: rtl/alien_sprite_renderer_march_fsm.sv
// Formation march controller: frame step counter, MARCH_R/MARCH_L/LANDED FSM, origin and landed.
// Optional ALIEN_ANIM_EN toggles a pose bit on every step.
module alien_march_fsm
   import alien_pkg::*;
#(
   parameter int COLS            = 8,
   parameter int ROWS            = 4,
   parameter int SPRITE_W        = 50,
   parameter int SPRITE_H        = 50,
   parameter int PITCH_X         = 60,
   parameter int PITCH_Y         = 60,
   parameter int START_X         = 20,
   parameter int START_Y         = 40,
   parameter int STEP_X          = 4,
   parameter int STEP_Y          = 16,
   parameter int RIGHT_BOUND     = 636,
   parameter int LEFT_BOUND      = 4,
   parameter int LAND_Y          = 420,
   parameter int FRAMES_PER_STEP = 8
)(
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_start,
   output logic [9:0] origin_x,
   output logic [9:0] origin_y,
   output logic       landed,
   output logic       frame
);

   localparam int FORM_W = form_w(COLS, PITCH_X, SPRITE_W);
   localparam int FORM_H = form_h(ROWS, PITCH_Y, SPRITE_H);
   localparam int CNT_W  = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

   march_state_t     state_reg, state_next;
   logic [CNT_W-1:0] step_cnt_reg;
   logic [9:0]       x_next, y_next;
   logic             landed_next, drop, step;

   assign step = frame_start && (step_cnt_reg == CNT_LAST);

   always_comb begin
      state_next  = state_reg;
      x_next      = origin_x;
      y_next      = origin_y;
      landed_next = landed;
      drop        = 1'b0;
      case (state_reg)
         MARCH_R: begin
            if (int'(origin_x) + STEP_X + FORM_W > RIGHT_BOUND) begin
               drop       = 1'b1;
               state_next = MARCH_L;
            end else begin
               x_next = origin_x + 10'(STEP_X);
            end
         end
         MARCH_L: begin
            if (int'(origin_x) < LEFT_BOUND + STEP_X) begin
               drop       = 1'b1;
               state_next = MARCH_R;
            end else begin
               x_next = origin_x - 10'(STEP_X);
            end
         end
         default: ;
      endcase
      // Landing is only possible on the step that drops the formation.
      if (drop) begin
         y_next = origin_y + 10'(STEP_Y);
         if (int'(y_next) + FORM_H >= LAND_Y) begin
            state_next  = LANDED;
            landed_next = 1'b1;
         end
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_reg    <= MARCH_R;
         step_cnt_reg <= '0;
         origin_x     <= 10'(START_X);
         origin_y     <= 10'(START_Y);
         landed       <= 1'b0;
         frame        <= 1'b0;
      end else if (frame_start) begin
         if (step) begin
            step_cnt_reg <= '0;
            state_reg    <= state_next;
            origin_x     <= x_next;
            origin_y     <= y_next;
            landed       <= landed_next;
`ifdef ALIEN_ANIM_EN
            frame        <= ~frame;
`else
            frame        <= 1'b0;
`endif
         end else begin
            step_cnt_reg <= step_cnt_reg + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/alien_sprite_renderer.sv
// Alien formation draw stage: 3-stage pixel pipeline over a 1-cycle-latency sprite RAM.
// Build with ALIEN_ANIM_EN defined for the two-pose (5000-entry) sprite RAM.
module alien_sprite_renderer
   import alien_pkg::*;
#(
   parameter int SPRITE_W        = 50,
   parameter int SPRITE_H        = 50,
   parameter int COLS            = 8,
   parameter int ROWS            = 4,
   parameter int PITCH_X         = 60,
   parameter int PITCH_Y         = 60,
   parameter int START_X         = 20,
   parameter int START_Y         = 40,
   parameter int STEP_X          = 4,
   parameter int STEP_Y          = 16,
   parameter int RIGHT_BOUND     = 636,
   parameter int LEFT_BOUND      = 4,
   parameter int LAND_Y          = 420,
   parameter int FRAMES_PER_STEP = 8
)(
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 frame_start,
   input  logic [ROWS*COLS-1:0] alive,
   alien_sprite_renderer_if.slave pix,
   output logic [9:0]           origin_x,
   output logic [9:0]           origin_y,
   output logic                 landed
);

   localparam int FORM_W = form_w(COLS, PITCH_X, SPRITE_W);
   localparam int FORM_H = form_h(ROWS, PITCH_Y, SPRITE_H);
   localparam int AREA   = SPRITE_W * SPRITE_H;

   logic frame;

   alien_march_fsm #(
      .COLS(COLS), .ROWS(ROWS), .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H),
      .PITCH_X(PITCH_X), .PITCH_Y(PITCH_Y), .START_X(START_X), .START_Y(START_Y),
      .STEP_X(STEP_X), .STEP_Y(STEP_Y), .RIGHT_BOUND(RIGHT_BOUND),
      .LEFT_BOUND(LEFT_BOUND), .LAND_Y(LAND_Y), .FRAMES_PER_STEP(FRAMES_PER_STEP)
   ) u_march (
      .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
      .origin_x(origin_x), .origin_y(origin_y), .landed(landed), .frame(frame)
   );

   // Bit 10 set means the pixel lies left of / above the origin.
   logic [10:0]          rx, ry, ox, oy;
   logic [COLS-1:0]      col_ge;
   logic [ROWS-1:0]      row_ge;
   int                   col_idx, row_idx;
   logic [ROWS*COLS-1:0] alive_shift;
   logic                 in_ext, hit_next, on_next;
   logic [18:0]          addr_next, pose_base;
   logic                 hit1_reg, hit2_reg;

   assign rx = {1'b0, pix.DrawX} - {1'b0, origin_x};
   assign ry = {1'b0, pix.DrawY} - {1'b0, origin_y};

   generate
      for (genvar gi = 0; gi < COLS; gi++) begin : g_col
         assign col_ge[gi] = (rx >= 11'(gi * PITCH_X));
      end
      for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
         assign row_ge[gi] = (ry >= 11'(gi * PITCH_Y));
      end
   endgenerate

   always_comb begin
      col_idx = 0;
      row_idx = 0;
      ox      = rx;
      oy      = ry;
      for (int c = 1; c < COLS; c++) begin
         if (col_ge[c]) begin
            col_idx = c;
            ox      = rx - 11'(c * PITCH_X);
         end
      end
      for (int r = 1; r < ROWS; r++) begin
         if (row_ge[r]) begin
            row_idx = r;
            oy      = ry - 11'(r * PITCH_Y);
         end
      end
      alive_shift = alive >> (row_idx * COLS + col_idx);
      in_ext      = !rx[10] && !ry[10] && (rx < 11'(FORM_W)) && (ry < 11'(FORM_H));
      hit_next    = in_ext && (ox < 11'(SPRITE_W)) && (oy < 11'(SPRITE_H)) && alive_shift[0];
      pose_base   = frame ? 19'(AREA) : 19'd0;
      addr_next   = hit_next ? (19'(oy) * 19'(SPRITE_W) + 19'(ox) + pose_base) : 19'd0;
      on_next     = hit2_reg && (pix.sprite_data != KEY_COLOR);
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         pix.read_address <= '0;
         hit1_reg         <= 1'b0;
         hit2_reg         <= 1'b0;
         pix.alien_on     <= 1'b0;
         pix.alien_color  <= '0;
      end else begin
         pix.read_address <= addr_next;
         hit1_reg         <= hit_next;
         hit2_reg         <= hit1_reg;
         pix.alien_on     <= on_next;
         pix.alien_color  <= on_next ? pix.sprite_data : 24'd0;
      end
   end

endmodule

// File: tb/tb_alien_sprite_renderer.sv
// Directed bench for alien_sprite_renderer: pixel pipeline, transparency, alive masking, march and landing.
module tb_alien_sprite_renderer;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        frame_start;
   logic [31:0] alive;
   logic [9:0]  origin_x, origin_y;
   logic        landed;
   logic [23:0] ram [0:4999];
   int          compared = 0;
   int          mismatched = 0;

   always #5 Clk = ~Clk;

   alien_sprite_renderer_if pix ();

   alien_sprite_renderer dut (
      .Clk(Clk), .Reset(Reset), .frame_start(frame_start), .alive(alive),
      .pix(pix), .origin_x(origin_x), .origin_y(origin_y), .landed(landed)
   );

   always @(posedge Clk) pix.sprite_data <= ram[pix.read_address];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pixel(input string tag, input int x, input int y,
                        input logic [18:0] ea, input logic eon, input logic [23:0] ecol);
      @(negedge Clk);
      pix.DrawX = 10'(x);
      pix.DrawY = 10'(y);
      @(negedge Clk);
      check({tag, "_addr"}, 32'(pix.read_address), 32'(ea));
      repeat (2) @(negedge Clk);
      check({tag, "_on"}, 32'(pix.alien_on), 32'(eon));
      check({tag, "_color"}, 32'(pix.alien_color), 32'(ecol));
      $display("pixel %s (%0d,%0d) addr=%0d on=%0b color=%06h", tag, x, y,
               pix.read_address, pix.alien_on, pix.alien_color);
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge Clk) frame_start = 1'b1;
         @(negedge Clk) frame_start = 1'b0;
      end
   endtask

   task automatic check_origin(input string tag, input int ex, input int ey, input logic el);
      check({tag, "_x"}, 32'(origin_x), 32'(ex));
      check({tag, "_y"}, 32'(origin_y), 32'(ey));
      check({tag, "_landed"}, 32'(landed), 32'(el));
      $display("march %s origin=(%0d,%0d) landed=%0b", tag, origin_x, origin_y, landed);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Reset       = 1'b1;
      frame_start = 1'b0;
      alive       = '1;
      pix.DrawX   = 10'd20;
      pix.DrawY   = 10'd40;
      for (int i = 0; i < 5000; i++) ram[i] = 24'h100000 + 24'(i);
      ram[0] = 24'h00FF00;

      repeat (3) @(negedge Clk);
      check("rst_addr", 32'(pix.read_address), 32'd0);
      check("rst_on", 32'(pix.alien_on), 32'd0);
      check("rst_color", 32'(pix.alien_color), 32'd0);
      check_origin("rst", 20, 40, 1'b0);

      // Pixel (20,40) held through release: output only after three edges.
      Reset = 1'b0;
      @(negedge Clk);
      check("rel1_addr", 32'(pix.read_address), 32'd0);
      check("rel1_on", 32'(pix.alien_on), 32'd0);
      @(negedge Clk);
      check("rel2_on", 32'(pix.alien_on), 32'd0);
      @(negedge Clk);
      check("rel3_on", 32'(pix.alien_on), 32'd1);
      check("rel3_color", 32'(pix.alien_color), 32'h00FF00);
      $display("release alien_on=%0b color=%06h", pix.alien_on, pix.alien_color);

      pixel("origin", 20, 40, 19'd0, 1'b1, 24'h00FF00);
      pixel("col_gap", 75, 40, 19'd0, 1'b0, 24'h0);
      pixel("c1r0", 80, 41, 19'd50, 1'b1, 24'h100032);
      pixel("row_gap", 20, 95, 19'd0, 1'b0, 24'h0);
      alive[9] = 1'b0;
      pixel("dead", 90, 105, 19'd0, 1'b0, 24'h0);
      alive[9] = 1'b1;
      pixel("alive", 90, 105, 19'd260, 1'b1, 24'h100104);
      ram[262] = 24'hFF00FF;
      pixel("key", 92, 105, 19'd262, 1'b0, 24'h0);
      pixel("left_miss", 19, 40, 19'd0, 1'b0, 24'h0);
      pixel("corner", 489, 269, 19'd2499, 1'b1, 24'h1009C3);
      pixel("right_out", 490, 40, 19'd0, 1'b0, 24'h0);
      pixel("below", 20, 270, 19'd0, 1'b0, 24'h0);
      pixel("offscreen", 1000, 1000, 19'd0, 1'b0, 24'h0);

      // Reset one cycle after a hit enters the pipe must swallow it.
      @(negedge Clk);
      pix.DrawX = 10'd20;
      pix.DrawY = 10'd40;
      @(negedge Clk);
      Reset     = 1'b1;
      pix.DrawX = 10'd0;
      pix.DrawY = 10'd0;
      @(negedge Clk);
      Reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         check("flush_on", 32'(pix.alien_on), 32'd0);
      end
      $display("flush alien_on=%0b", pix.alien_on);

      pulses(7);
      check_origin("f7", 20, 40, 1'b0);
      pulses(1);
      check_origin("step1", 24, 40, 1'b0);
      pixel("moved", 24, 40, 19'd0, 1'b1, 24'h00FF00);
      pixel("old_pos", 20, 40, 19'd0, 1'b0, 24'h0);
      pulses(8 * 35);
      check_origin("step36", 164, 40, 1'b0);
      pulses(8);
      check_origin("step37_drop", 164, 56, 1'b0);
      pulses(8);
      check_origin("step38_left", 160, 56, 1'b0);
      pulses(8 * 326);
      check_origin("step364", 164, 168, 1'b0);
      pulses(8);
      check_origin("step365_drop", 164, 184, 1'b0);
      pulses(8 * 40);
      check_origin("step405", 4, 184, 1'b0);
      pulses(8);
      check_origin("step406_land", 4, 200, 1'b1);
      pulses(100);
      check_origin("frozen", 4, 200, 1'b1);

      @(negedge Clk) Reset = 1'b1;
      @(negedge Clk) Reset = 1'b0;
      check_origin("rst2", 20, 40, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
